// File: rtl/mips_div_pkg.sv
// Shared definitions for the sequential divider: default width, FSM states
// and the quotient returned on divide-by-zero.
package mips_div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  // Wide enough for any supported WIDTH (<= 64); users take the low WIDTH bits.
  localparam logic [63:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference when it does not borrow.
module div_step
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           no_borrow;
  logic           unused_rem_msb;

  // The partial remainder is always below the divisor, so its MSB is zero here.
  assign unused_rem_msb = rem_i[WIDTH];
  assign shifted        = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};

  ripple_adder #(.WIDTH(WIDTH + 1)) u_sub (
    .a_i    (shifted),
    .b_i    (~{1'b0, divisor_i}),
    .cin_i  (1'b1),
    .sum_o  (diff),
    .cout_o (no_borrow)
  );

  assign rem_o = no_borrow ? diff : shifted;
  assign quo_o = {quo_i[WIDTH-2:0], no_borrow};

endmodule

// File: rtl/ripple_adder.sv
// Plain ripple-carry adder used for the divider's trial subtraction.
module ripple_adder #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  always_comb begin
    logic carry;
    // NOTE: blocking '=' in combinational logic so each bit sees the carry just computed.
    carry = cin_i;
    sum_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (DIV/DIVU). Define DIV_SIGNED_EN to honour
// is_signed; otherwise every operation is unsigned with identical latency.
module seq_divider
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;
  logic             done_q, done_d;

  logic             signed_op;
  logic [WIDTH-1:0] abs_dividend, abs_divisor;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;

`ifdef DIV_SIGNED_EN
  assign signed_op = is_signed;
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign signed_op        = 1'b0;
`endif

  assign abs_dividend = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
  assign abs_divisor  = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    // NOTE: every next-state value gets a default first so no path infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          neg_quo_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem_d = signed_op & dividend[WIDTH-1];
          cnt_d     = '0;
          if (divisor == '0) begin
            // Keep the raw dividend so it can be returned as the remainder.
            dz_d    = 1'b1;
            rem_d   = {1'b0, dividend};
            state_d = FIX;
          end else begin
            dz_d    = 1'b0;
            rem_d   = '0;
            quo_d   = abs_dividend;
            dvsr_d  = abs_divisor;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        state_d    = IDLE;
        done_d     = 1'b1;
        div_zero_d = dz_q;
        if (dz_q) begin
          quotient_d  = DIV_ZERO_QUOT[WIDTH-1:0];
          remainder_d = rem_q[WIDTH-1:0];
        end else begin
          quotient_d  = neg_quo_q ? -quo_q : quo_q;
          remainder_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking '<=' for all state so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits.
REQ-002 SHALL have one clock; reset is synchronous and active-low.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port: start  input  1  request a division; sampled only when not busy.
REQ-006 SHALL have port: is_signed  input  1  1 = two's-complement DIV, 0 = DIVU; sampled with start.
REQ-007 SHALL have port: dividend  input  WIDTH  numerator; sampled with start.
REQ-008 SHALL have port: divisor  input  WIDTH  denominator; sampled with start.
REQ-009 SHALL have port: busy  output  1  operation in progress.
REQ-010 SHALL have port: done  output  1  one-cycle pulse; results valid.
REQ-011 SHALL have port: quotient  output  WIDTH  LO result.
REQ-012 SHALL have port: remainder  output  WIDTH  HI result.
REQ-013 SHALL have port: div_zero  output  1  last operation had divisor == 0.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and FIX.
- IDLE->RUN: start=1 and divisor!=0.
- IDLE->FIX: start=1 and divisor==0.
- RUN->FIX: after exactly WIDTH iterations.
- FIX->IDLE: unconditional.
REQ-015 SHALL perform one restoring shift-subtract iteration per RUN cycle on operand magnitudes, using WIDTH+1-bit partial remainder; the subtract borrow selects the quotient bit.
REQ-016 SHALL in FIX apply sign correction (quotient negated iff operand signs differ; remainder takes dividend sign), register quotient, remainder and div_zero, and assert done for the following cycle only.
REQ-017 SHALL produce done WIDTH+1 cycles after the start-sampling edge (33 for WIDTH=32); divide-by-zero done 1 cycle after.
REQ-018 SHALL hold busy=1 in RUN and FIX, 0 in IDLE; done and busy never both 1.
REQ-019 SHALL ignore start while busy=1; start in the same cycle as done=1 SHALL be accepted.
REQ-020 SHALL hold quotient/remainder/div_zero stable from done until the next FIX completes.
REQ-021 SHALL on divisor==0 return quotient = all ones, remainder = dividend, div_zero=1; otherwise div_zero=0.
REQ-022 SHALL on signed most-negative / -1 return quotient = most-negative, remainder = 0, no flag.

Reset
REQ-023 SHALL on rst_n=0 at a clock edge enter IDLE and clear busy, done, quotient, remainder, div_zero to 0, including mid-operation (operation discarded).
REQ-024 SHALL ignore start in any cycle where rst_n=0.

Configuration
REQ-025 SHALL with DIV_SIGNED_EN defined honour is_signed per REQ-016/022.
REQ-026 SHALL without DIV_SIGNED_EN ignore is_signed, treat all operands unsigned, make FIX pass results through unchanged, and keep latency identical.

Structure
REQ-027 SHALL take WIDTH default, FSM state enum and the divide-by-zero quotient constant from shared package mips_div_pkg.
REQ-028 SHALL place one iteration (shift, trial subtract, select) in sub-module div_step, built on the team's existing ripple adder with cin=1 and inverted divisor.

Verification
REQ-029 SHALL cover unsigned 100/7 -> quotient 14, remainder 2, done exactly 33 cycles after start, div_zero 0.
REQ-030 SHALL cover signed 0xFFFFFFF9/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; with macro off -> quotient 0x7FFFFFFC, remainder 1.
REQ-031 SHALL cover 5/0 -> quotient 0xFFFFFFFF, remainder 5, div_zero 1, done 1 cycle after start.
REQ-032 SHALL cover signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-033 SHALL cover second start 5 cycles into RUN -> ignored, first result unchanged; back-to-back start on done cycle -> accepted, next done 33 cycles later.
REQ-034 SHALL cover rst_n=0 at cycle 10 of RUN -> next cycle busy 0, done 0, outputs 0; no done pulse follows.
